// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads an IMG_W x IMG_H greyscale image and
// streams a WIN x WIN window (fit, zoomed, panned, mirrored) after every command.
module lcd_ctrl_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 12,
    parameter int IMG_H = 9,
    parameter int WIN   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] datain,
    output logic          busy,
    output logic          output_valid,
    output logic [DW-1:0] dataout
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NWIN = WIN * WIN;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int XW   = $clog2(IMG_W + 1);
    localparam int YW   = $clog2(IMG_H + 1);
    localparam int RW   = $clog2(WIN + 1);
    localparam int SX   = IMG_W / WIN;
    localparam int SY   = IMG_H / WIN;

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - WIN);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - WIN);
    localparam logic [XW-1:0] X_CTR = XW'((IMG_W - WIN) / 2);
    localparam logic [YW-1:0] Y_CTR = YW'((IMG_H - WIN) / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [RW-1:0] col_q, col_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [YW-1:0] y0_q, y0_d;
    logic          zoom_in_q, zoom_in_d;
    logic          mirror_h_q, mirror_h_d;
    logic          mirror_v_q, mirror_v_d;
    logic          ovalid_q, ovalid_d;
    logic [DW-1:0] dout_q, dout_d;

    logic [DW-1:0] img_q [NPIX];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic [31:0]   rr, cc, px_x, px_y;
    logic [AW-1:0] rd_addr;

    // Image RAM holds its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            img_q[mem_waddr] <= mem_wdata;
        end
    end

    // Window (row, col) -> image address; row/col never leave [0, WIN-1].
    always_comb begin
        rr = mirror_v_q ? (32'(WIN - 1) - 32'(row_q)) : 32'(row_q);
        cc = mirror_h_q ? (32'(WIN - 1) - 32'(col_q)) : 32'(col_q);
        if (zoom_in_q) begin
            px_y = 32'(y0_q) + rr;
            px_x = 32'(x0_q) + cc;
        end else begin
            px_y = rr * 32'(SY) + 32'(SY / 2);
            px_x = cc * 32'(SX) + 32'(SX / 2);
        end
        rd_addr = AW'(px_y * 32'(IMG_W) + px_x);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        zoom_in_d  = zoom_in_q;
        mirror_h_d = mirror_h_q;
        mirror_v_d = mirror_v_q;
        ovalid_d   = 1'b0;
        dout_d     = '0;
        mem_we     = 1'b0;
        mem_waddr  = AW'(cnt_q);
        mem_wdata  = datain;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cnt_d   = '0;
                    state_d = (cmd == 4'd0) ? S_LOAD : S_CALC;
                    case (cmd)
                        4'd1: begin
                            zoom_in_d = 1'b1;
                            x0_d      = X_CTR;
                            y0_d      = Y_CTR;
                        end
                        4'd2: zoom_in_d = 1'b0;
                        4'd3: if (zoom_in_q && x0_q < X_MAX) x0_d = x0_q + 1'b1;
                        4'd4: if (zoom_in_q && x0_q != '0) x0_d = x0_q - 1'b1;
                        4'd5: if (zoom_in_q && y0_q != '0) y0_d = y0_q - 1'b1;
                        4'd6: if (zoom_in_q && y0_q < Y_MAX) y0_d = y0_q + 1'b1;
                        4'd7: mirror_h_d = ~mirror_h_q;
                        4'd8: mirror_v_d = ~mirror_v_q;
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                mem_we = 1'b1;
                if (cnt_q == CW'(NPIX - 1)) begin
                    state_d    = S_CALC;
                    cnt_d      = '0;
                    zoom_in_d  = 1'b0;
                    x0_d       = X_CTR;
                    y0_d       = Y_CTR;
                    mirror_h_d = 1'b0;
                    mirror_v_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CALC: begin
                state_d = S_OUT;
                cnt_d   = '0;
                row_d   = '0;
                col_d   = '0;
            end
            S_OUT: begin
                // cnt == NWIN is the drain cycle: last beat is on the wire, busy still high.
                if (cnt_q < CW'(NWIN)) begin
                    ovalid_d = 1'b1;
                    dout_d   = img_q[rd_addr];
                    cnt_d    = cnt_q + 1'b1;
                    if (col_q == RW'(WIN - 1)) begin
                        col_d = '0;
                        row_d = (row_q == RW'(WIN - 1)) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            x0_q       <= X_CTR;
            y0_q       <= Y_CTR;
            zoom_in_q  <= 1'b0;
            mirror_h_q <= 1'b0;
            mirror_v_q <= 1'b0;
            ovalid_q   <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            zoom_in_q  <= zoom_in_d;
            mirror_h_q <= mirror_h_d;
            mirror_v_q <= mirror_v_d;
            ovalid_q   <= ovalid_d;
            dout_q     <= dout_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign output_valid = ovalid_q;
    assign dataout      = dout_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: image pixel p[r][c] = r*12+c, vector table of
// commands with expected 16-beat windows, plus load, busy-ignore and reset sequences.
module tb_lcd_ctrl_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic [7:0] datain = 8'd0;
    logic       busy;
    logic       output_valid;
    logic [7:0] dataout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_ctrl_param #(
        .DW(8), .IMG_W(12), .IMG_H(9), .WIN(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .datain      (datain),
        .busy        (busy),
        .output_valid(output_valid),
        .dataout     (dataout)
    );

    typedef logic [16*8-1:0] win_t;
    typedef struct {
        logic [3:0] op;
        logic       hold;
        win_t       exp;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] beat_of(input win_t w, input int i);
        return w[(15 - i) * 8 +: 8];
    endfunction

    // Called right after the edge that enters CALC; ends one cycle after busy falls.
    task automatic collect(input win_t w, input string name);
        @(posedge clk); #1;
        check($sformatf("%s calc_valid", name), output_valid, 0);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s valid%0d", name, i), output_valid, 1);
            check($sformatf("%s beat%0d", name, i), dataout, beat_of(w, i));
            if (i == 15) check($sformatf("%s busy_last", name), busy, 1);
        end
        @(posedge clk); #1;
        check($sformatf("%s end_valid", name), output_valid, 0);
        check($sformatf("%s end_busy", name), busy, 0);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic hold, input win_t w, input string name);
        @(negedge clk);
        check($sformatf("%s idle", name), busy, 0);
        cmd = op;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s busy", name), busy, 1);
        if (hold) cmd = 4'd3;
        else cmd_valid = 1'b0;
        collect(w, name);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic hold, input win_t w);
        vec_t v;
        v.op = op;
        v.hold = hold;
        v.exp = w;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        win_t fit_plain;
        fit_plain = {8'd13, 8'd16, 8'd19, 8'd22, 8'd37, 8'd40, 8'd43, 8'd46,
                     8'd61, 8'd64, 8'd67, 8'd70, 8'd85, 8'd88, 8'd91, 8'd94};

        vecs[0]  = mk(4'd1, 0, {8'd28,8'd29,8'd30,8'd31,8'd40,8'd41,8'd42,8'd43,8'd52,8'd53,8'd54,8'd55,8'd64,8'd65,8'd66,8'd67});
        vecs[1]  = mk(4'd3, 0, {8'd29,8'd30,8'd31,8'd32,8'd41,8'd42,8'd43,8'd44,8'd53,8'd54,8'd55,8'd56,8'd65,8'd66,8'd67,8'd68});
        vecs[2]  = mk(4'd3, 0, {8'd30,8'd31,8'd32,8'd33,8'd42,8'd43,8'd44,8'd45,8'd54,8'd55,8'd56,8'd57,8'd66,8'd67,8'd68,8'd69});
        vecs[3]  = mk(4'd3, 0, {8'd31,8'd32,8'd33,8'd34,8'd43,8'd44,8'd45,8'd46,8'd55,8'd56,8'd57,8'd58,8'd67,8'd68,8'd69,8'd70});
        vecs[4]  = mk(4'd3, 0, {8'd32,8'd33,8'd34,8'd35,8'd44,8'd45,8'd46,8'd47,8'd56,8'd57,8'd58,8'd59,8'd68,8'd69,8'd70,8'd71});
        vecs[5]  = mk(4'd3, 0, {8'd32,8'd33,8'd34,8'd35,8'd44,8'd45,8'd46,8'd47,8'd56,8'd57,8'd58,8'd59,8'd68,8'd69,8'd70,8'd71});
        // SHIFT_L while SHIFT_R is held on cmd_valid during busy: the held strobes must be ignored
        vecs[6]  = mk(4'd4, 1, {8'd31,8'd32,8'd33,8'd34,8'd43,8'd44,8'd45,8'd46,8'd55,8'd56,8'd57,8'd58,8'd67,8'd68,8'd69,8'd70});
        vecs[7]  = mk(4'd6, 0, {8'd43,8'd44,8'd45,8'd46,8'd55,8'd56,8'd57,8'd58,8'd67,8'd68,8'd69,8'd70,8'd79,8'd80,8'd81,8'd82});
        vecs[8]  = mk(4'd6, 0, {8'd55,8'd56,8'd57,8'd58,8'd67,8'd68,8'd69,8'd70,8'd79,8'd80,8'd81,8'd82,8'd91,8'd92,8'd93,8'd94});
        vecs[9]  = mk(4'd6, 0, {8'd67,8'd68,8'd69,8'd70,8'd79,8'd80,8'd81,8'd82,8'd91,8'd92,8'd93,8'd94,8'd103,8'd104,8'd105,8'd106});
        vecs[10] = mk(4'd6, 0, {8'd67,8'd68,8'd69,8'd70,8'd79,8'd80,8'd81,8'd82,8'd91,8'd92,8'd93,8'd94,8'd103,8'd104,8'd105,8'd106});
        vecs[11] = mk(4'd5, 0, {8'd55,8'd56,8'd57,8'd58,8'd67,8'd68,8'd69,8'd70,8'd79,8'd80,8'd81,8'd82,8'd91,8'd92,8'd93,8'd94});
        vecs[12] = mk(4'd7, 0, {8'd58,8'd57,8'd56,8'd55,8'd70,8'd69,8'd68,8'd67,8'd82,8'd81,8'd80,8'd79,8'd94,8'd93,8'd92,8'd91});
        vecs[13] = mk(4'd8, 0, {8'd94,8'd93,8'd92,8'd91,8'd82,8'd81,8'd80,8'd79,8'd70,8'd69,8'd68,8'd67,8'd58,8'd57,8'd56,8'd55});
        vecs[14] = mk(4'd2, 0, {8'd94,8'd91,8'd88,8'd85,8'd70,8'd67,8'd64,8'd61,8'd46,8'd43,8'd40,8'd37,8'd22,8'd19,8'd16,8'd13});
        vecs[15] = mk(4'd8, 0, {8'd22,8'd19,8'd16,8'd13,8'd46,8'd43,8'd40,8'd37,8'd70,8'd67,8'd64,8'd61,8'd94,8'd91,8'd88,8'd85});
        vecs[16] = mk(4'd12,0, {8'd22,8'd19,8'd16,8'd13,8'd46,8'd43,8'd40,8'd37,8'd70,8'd67,8'd64,8'd61,8'd94,8'd91,8'd88,8'd85});
        vecs[17] = mk(4'd5, 0, {8'd22,8'd19,8'd16,8'd13,8'd46,8'd43,8'd40,8'd37,8'd70,8'd67,8'd64,8'd61,8'd94,8'd91,8'd88,8'd85});
        vecs[18] = mk(4'd1, 0, {8'd31,8'd30,8'd29,8'd28,8'd43,8'd42,8'd41,8'd40,8'd55,8'd54,8'd53,8'd52,8'd67,8'd66,8'd65,8'd64});
        vecs[19] = mk(4'd5, 0, {8'd19,8'd18,8'd17,8'd16,8'd31,8'd30,8'd29,8'd28,8'd43,8'd42,8'd41,8'd40,8'd55,8'd54,8'd53,8'd52});
        vecs[20] = mk(4'd5, 0, {8'd7,8'd6,8'd5,8'd4,8'd19,8'd18,8'd17,8'd16,8'd31,8'd30,8'd29,8'd28,8'd43,8'd42,8'd41,8'd40});
        vecs[21] = mk(4'd5, 0, {8'd7,8'd6,8'd5,8'd4,8'd19,8'd18,8'd17,8'd16,8'd31,8'd30,8'd29,8'd28,8'd43,8'd42,8'd41,8'd40});
        vecs[22] = mk(4'd4, 0, {8'd6,8'd5,8'd4,8'd3,8'd18,8'd17,8'd16,8'd15,8'd30,8'd29,8'd28,8'd27,8'd42,8'd41,8'd40,8'd39});
        vecs[23] = mk(4'd4, 0, {8'd5,8'd4,8'd3,8'd2,8'd17,8'd16,8'd15,8'd14,8'd29,8'd28,8'd27,8'd26,8'd41,8'd40,8'd39,8'd38});
        vecs[24] = mk(4'd4, 0, {8'd4,8'd3,8'd2,8'd1,8'd16,8'd15,8'd14,8'd13,8'd28,8'd27,8'd26,8'd25,8'd40,8'd39,8'd38,8'd37});
        vecs[25] = mk(4'd4, 0, {8'd3,8'd2,8'd1,8'd0,8'd15,8'd14,8'd13,8'd12,8'd27,8'd26,8'd25,8'd24,8'd39,8'd38,8'd37,8'd36});
        vecs[26] = mk(4'd4, 0, {8'd3,8'd2,8'd1,8'd0,8'd15,8'd14,8'd13,8'd12,8'd27,8'd26,8'd25,8'd24,8'd39,8'd38,8'd37,8'd36});

        // Reset state
        #1;
        check("rst busy", busy, 0);
        check("rst valid", output_valid, 0);
        check("rst dout", dataout, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // LOAD: pixel at row-major index i is r*12+c == i
        @(negedge clk);
        cmd = 4'd0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("load busy", busy, 1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 108; i++) begin
            datain = 8'(i);
            @(posedge clk); #1;
            if (i == 50) begin
                check("load mid_busy", busy, 1);
                check("load mid_valid", output_valid, 0);
            end
        end
        datain = 8'd0;
        collect(fit_plain, "load");

        for (int v = 0; v < NVEC; v++) begin
            run_cmd(vecs[v].op, vecs[v].hold, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Reset on the 5th OUT beat of a mirrored ZOOM_IN
        @(negedge clk);
        cmd = 4'd1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("pre_rst beat%0d", i), dataout, beat_of(vecs[18].exp, i));
        end
        reset = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort valid", output_valid, 0);
        check("abort dout", dataout, 0);
        @(posedge clk); #1;
        check("abort hold_valid", output_valid, 0);
        @(negedge clk);
        reset = 1'b1;

        // Retained image, FIT mode and cleared mirrors after reset
        run_cmd(4'd12, 0, fit_plain, "post_rst_nop");
        run_cmd(4'd1, 0, vecs[0].exp, "post_rst_zoom");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
